// File: rtl/rr_mux_arbiter_8_pkg.sv
// Shared constants for the rr_mux_arbiter_8 codebase slice: FSM encoding,
// requester count and select width, plus a one-hot helper.
package rr_mux_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_REQ-1:0] one;
    one = NUM_REQ'(1);
    return one << s;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_8_mux.sv
// MUX8T1_8: the existing 8-bit 8-to-1 multiplexer driven by the arbiter's select.
module MUX8T1_8 (
  input  logic [7:0] I0,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic [7:0] I3,
  input  logic [7:0] I4,
  input  logic [7:0] I5,
  input  logic [7:0] I6,
  input  logic [7:0] I7,
  input  logic [2:0] s,
  output logic [7:0] o
);

  always_comb begin
    o = I0;
    case (s)
      3'd0: o = I0;
      3'd1: o = I1;
      3'd2: o = I2;
      3'd3: o = I3;
      3'd4: o = I4;
      3'd5: o = I5;
      3'd6: o = I6;
      3'd7: o = I7;
      default: o = I0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter/sequencer sharing one 8-bit valid/ready channel among 8
// requesters via MUX8T1_8. Optional stall timeout: define ARB_TIMEOUT_EN.
module rr_mux_arbiter_8
  import rr_mux_arbiter_8_pkg::*;
#(
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] I0,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic [7:0] I3,
  input  logic [7:0] I4,
  input  logic [7:0] I5,
  input  logic [7:0] I6,
  input  logic [7:0] I7,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] gnt,
  output logic [7:0] ack,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  // Channel handshake: a byte moves on every cycle where out_valid and
  // out_ready are both high; out_valid follows the granted req line, so a
  // requester withdraws its byte simply by dropping req.

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic             state;
  logic [SEL_W-1:0] last;
  logic [7:0]       cnt;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] cand;
  logic             pick_found;
  logic             xfer;
  logic             burst_done;
  logic             stall_hit;
  logic             release_grant;

  // busy is the registered FSM state, so checkers can bind to it directly.
  assign busy          = (state == ST_BUSY);
  assign out_valid     = busy & req[sel];
  assign xfer          = out_valid & out_ready;
  assign ack           = gnt & {NUM_REQ{xfer}};
  assign burst_done    = xfer & (cnt == BURST_LAST);
  assign release_grant = busy & (burst_done | ~req[sel] | stall_hit);

  // Search starts just past the last granted requester and wraps modulo 8.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      sel   <= '0;
      cnt   <= '0;
      last  <= SEL_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state <= ST_BUSY;
            sel   <= pick_idx;
            gnt   <= sel_onehot(pick_idx);
            cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (release_grant) begin
            state <= ST_IDLE;
            gnt   <= '0;
            last  <= sel;
            cnt   <= '0;
          end else if (xfer) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] stall;
  logic       timeout_q;

  assign stall_hit = out_valid & ~out_ready & (stall == STALL_LAST);
  assign timeout   = timeout_q;

  // The pulse is registered so it lines up with the cycle gnt first reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall_hit;
      if (!busy || release_grant || xfer) begin
        stall <= '0;
      end else if (out_valid && !out_ready) begin
        stall <= stall + 8'd1;
      end
    end
  end
`else
  assign stall_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  MUX8T1_8 u_mux (
    .I0 (I0),
    .I1 (I1),
    .I2 (I2),
    .I3 (I3),
    .I4 (I4),
    .I5 (I5),
    .I6 (I6),
    .I7 (I7),
    .s  (sel),
    .o  (out_data)
  );

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Self-checking bench for rr_mux_arbiter_8: vector table, directed corner
// sequences and a randomized run against a behavioural arbiter model.
module tb_rr_mux_arbiter_8;

  localparam int MAXB = 4;
  localparam int TOC  = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] din [8];
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] gnt;
  logic [7:0] ack;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_mux_arbiter_8 #(.MAX_BURST(MAXB), .TIMEOUT_CYC(TOC)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .I0        (din[0]),
    .I1        (din[1]),
    .I2        (din[2]),
    .I3        (din[3]),
    .I4        (din[4]),
    .I5        (din[5]),
    .I6        (din[6]),
    .I7        (din[7]),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .gnt       (gnt),
    .ack       (ack),
    .sel       (sel),
    .busy      (busy),
    .timeout   (timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_fixed_data();
    din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'hA5; din[3] = 8'h44;
    din[4] = 8'h55; din[5] = 8'h66; din[6] = 8'h77; din[7] = 8'h88;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_gnt, input logic e_vld,
                           input logic [7:0] e_ack, input logic e_busy, input logic [2:0] e_sel,
                           input logic [7:0] e_data, input logic e_to);
    check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_vld));
    check({tag, ".ack"},       32'(ack),       32'(e_ack));
    check({tag, ".busy"},      32'(busy),      32'(e_busy));
    check({tag, ".sel"},       32'(sel),       32'(e_sel));
    check({tag, ".out_data"},  32'(out_data),  32'(e_data));
    check({tag, ".timeout"},   32'(timeout),   32'(e_to));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] gnt;
    logic       vld;
    logic [7:0] ack;
    logic       busy;
    logic [2:0] sel;
    logic [7:0] data;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  function automatic vec_t mk(logic r, logic [7:0] q, logic y, logic [7:0] g, logic v,
                              logic [7:0] a, logic b, logic [2:0] s, logic [7:0] d);
    vec_t t;
    t.rst = r; t.req = q; t.rdy = y; t.gnt = g; t.vld = v;
    t.ack = a; t.busy = b; t.sel = s; t.data = d;
    return t;
  endfunction

  task automatic fill_table();
    //            rst  req    rdy  gnt    vld  ack    busy sel   data
    tbl[0]  = mk(1'b0, 8'h04, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h11);
    tbl[1]  = mk(1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA5);
    tbl[2]  = mk(1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA5);
    tbl[3]  = mk(1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA5);
    tbl[4]  = mk(1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA5);
    tbl[5]  = mk(1'b0, 8'h04, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 8'hA5);
    tbl[6]  = mk(1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA5);
    tbl[7]  = mk(1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 3'd2, 8'hA5);
    tbl[8]  = mk(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 8'hA5);
    tbl[9]  = mk(1'b0, 8'h20, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 8'hA5);
    tbl[10] = mk(1'b0, 8'h20, 1'b0, 8'h20, 1'b1, 8'h00, 1'b1, 3'd5, 8'h66);
    tbl[11] = mk(1'b0, 8'h01, 1'b0, 8'h20, 1'b0, 8'h00, 1'b1, 3'd5, 8'h66);
    tbl[12] = mk(1'b0, 8'h21, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd5, 8'h66);
    tbl[13] = mk(1'b0, 8'h21, 1'b1, 8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 8'h11);
    tbl[14] = mk(1'b1, 8'h21, 1'b0, 8'h01, 1'b1, 8'h00, 1'b1, 3'd0, 8'h11);
    tbl[15] = mk(1'b0, 8'h80, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h11);
    tbl[16] = mk(1'b0, 8'h80, 1'b1, 8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 8'h88);
    tbl[17] = mk(1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'h00, 1'b1, 3'd7, 8'h88);
    tbl[18] = mk(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd7, 8'h88);
  endtask

  // ---------------- behavioural reference model ----------------
  int m_owner;   // granted requester, -1 when nobody holds the channel
  int m_sel;
  int m_last;
  int m_nx;      // transfers completed in the current grant
  int m_stall;   // consecutive stalled cycles in the current grant
  bit m_to;

  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_last = 7; m_nx = 0; m_stall = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic [7:0] q, input logic rdy);
    bit vld, xf, stalled, hit, found;
    int i;
    if (r) begin
      model_reset();
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
          i = (m_last + k) % 8;
          if (!found && q[i]) begin
            found = 1'b1; m_owner = i; m_sel = i; m_nx = 0; m_stall = 0;
          end
        end
      end else begin
        vld     = q[m_owner];
        xf      = vld && rdy;
        stalled = vld && !rdy;
        hit     = TO_EN && stalled && (m_stall == TOC - 1);
        if ((xf && (m_nx + 1 == MAXB)) || !vld || hit) begin
          m_last = m_owner; m_owner = -1; m_stall = 0; m_to = hit;
        end else if (xf) begin
          m_nx++; m_stall = 0;
        end else if (stalled) begin
          m_stall++;
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] e_gnt, e_ack, prev_ack;
    logic       e_vld;
    int         g, ph, k, last_c;

    rst = 1'b1; req = 8'h00; out_ready = 1'b0;
    set_fixed_data();
    fill_table();

    // Reset, then idle with no requests.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); req = 8'h00; out_ready = 1'b1; #1;
      check("idle.gnt", 32'(gnt), 32'h0);
      check("idle.out_valid", 32'(out_valid), 32'h0);
      check("idle.busy", 32'(busy), 32'h0);
      check("idle.sel", 32'(sel), 32'h0);
    end

    // Table: burst, rotation, req drop, reset mid-grant.
    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      rst = tbl[v].rst; req = tbl[v].req; out_ready = tbl[v].rdy;
      #1;
      check_all($sformatf("vec%0d", v), tbl[v].gnt, tbl[v].vld, tbl[v].ack,
                tbl[v].busy, tbl[v].sel, tbl[v].data, 1'b0);
    end
    rst = 1'b0;

    // Fairness with all requesters active: grants 0..7,0 spaced by burst+bubble.
    do_reset();
    for (int c = 0; c < 9 * (MAXB + 1); c++) begin
      @(negedge clk); req = 8'hFF; out_ready = 1'b1; #1;
      k  = c / (MAXB + 1);
      ph = c % (MAXB + 1);
      g  = k % 8;
      if (ph == 0) begin
        check($sformatf("fair%0d.bubble_gnt", k), 32'(gnt), 32'h0);
      end else begin
        check($sformatf("fair%0d.gnt", k), 32'(gnt), 32'(8'd1 << g));
        check($sformatf("fair%0d.ack", k), 32'(ack), 32'(8'd1 << g));
        check($sformatf("fair%0d.data", k), 32'(out_data), 32'(din[g]));
      end
    end

    // Stalled grant: forced release with timeout enabled, held forever otherwise.
    do_reset();
    last_c = TO_EN ? (TOC + 2) : 100;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk); req = 8'h08; out_ready = 1'b0; #1;
      if (c == 0) e_gnt = 8'h00;
      else if (TO_EN && c == TOC + 1) e_gnt = 8'h00;
      else e_gnt = 8'h08;
      check($sformatf("stall%0d.gnt", c), 32'(gnt), 32'(e_gnt));
      check($sformatf("stall%0d.timeout", c), 32'(timeout), 32'(TO_EN && c == TOC + 1));
      check($sformatf("stall%0d.ack", c), 32'(ack), 32'h0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    req = 8'h00;
    prev_ack = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (!req[i]) begin
          din[i] = 8'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if (prev_ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else din[i] = 8'($urandom);
        end else if ($urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
      out_ready = ((c % 200) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      #1;
      e_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
      e_vld = (m_owner >= 0) && req[m_owner];
      e_ack = (e_vld && out_ready) ? e_gnt : 8'h00;
      check_all($sformatf("rnd%0d", c), e_gnt, e_vld, e_ack, m_owner >= 0,
                3'(m_sel), din[m_sel], m_to);
      prev_ack = e_ack;
      model_step(rst, req, out_ready);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
